ntt_4_sched: RTL and testbench
==============================

# ntt_4_sched

Sequencing controller for the combinational 4-point NTT core `ntt_4`. It accepts coefficients one per handshake on a 9-bit stream and packs four of them into the core's 36-bit input. It then registers the core's 36-bit result and streams the four result words back out under valid/ready flow control. It sits between a serial coefficient source (memory reader or upstream stage) and a serial consumer, and owns the only `ntt_4` instance on that path.

## Interface
- `COEF_W`, default 9: coefficient width. It must equal the `ntt_4` lane width; the frame is 4*COEF_W = 36 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a coefficient.
- `in_ready`  out  1  block accepts a coefficient this cycle.
- `in_data`  in  COEF_W  coefficient; the first accepted word of a frame is coefficient 0.
- `out_valid`  out  1  `out_data` holds a result word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_data`  out  COEF_W  result word; result 0 is emitted first.
- `busy`  out  1  high in COMPUTE and UNLOAD.
- `frames_done`  out  16  count of fully unloaded frames; wraps.

## Operation
- States: LOAD, COMPUTE, UNLOAD. Reset state is LOAD.
- Holding registers:
  - `in_buf[35:0]`: input frame.
  - `res_buf[35:0]`: captured core result.
  - `cnt[1:0]`: word index.
- `ntt_4` input is driven by `in_buf`. Its output `an` is sampled only in COMPUTE.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `in_buf[COEF_W*cnt +: COEF_W]` <= `in_data` and `cnt` increments.
  - On the accept with `cnt`==3: `cnt` <= 0 and go to COMPUTE.
- COMPUTE: lasts exactly one cycle. `res_buf` <= `an`, `in_ready`=0, then go to UNLOAD.
- UNLOAD:
  - `out_valid`=1 and `out_data` = `res_buf[COEF_W*cnt +: COEF_W]`.
  - On `out_valid && out_ready`: `cnt` increments.
  - On the accept with `cnt`==3: `cnt` <= 0, `frames_done` increments, go to LOAD.
- `in_ready`=0 in COMPUTE and UNLOAD. `in_valid` is ignored there and no data is lost; the source holds.
- No modular arithmetic in this block. Values pass through bit-exact and all arithmetic is inside `ntt_4`.
- `frames_done` wraps from 16'hFFFF to 0 without saturation.

## Timing
- Reset values:
  - state=LOAD, `cnt`=0.
  - `in_buf`=0, `res_buf`=0.
  - `in_ready`=1 from the first cycle after `rst` deasserts; it is 0 while `rst` is high.
  - `out_valid`=0, `out_data`=0, `busy`=0, `frames_done`=0.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to them.
- Latency: the 4th input accept at edge t gives COMPUTE in cycle t+1 and `out_valid`=1 from cycle t+2.
- Minimum frame period is 9 cycles (4 load + 1 compute + 4 unload) with both sides always ready.
- Back-to-back: the cycle after the last output accept, `in_ready`=1 again.
- Stall: while `out_valid && !out_ready`, `out_data` and `cnt` hold stable for any number of cycles.
- Gaps in `in_valid` during LOAD leave `cnt` and `in_buf` unchanged.
- `rst` asserted in any state, mid-load or mid-unload, returns all registers to reset values on that edge. A partially loaded frame is discarded, and an unloaded result is dropped without incrementing `frames_done`.

## Test plan
- **Single frame, all ones.** After reset, feed coefficients 1,1,1,1, so `in_buf`=36'h008040201.
  - `out_valid` must rise exactly 2 cycles after the 4th accept.
  - The four output words must equal the four 9-bit lanes, low lane first, of a golden `ntt_4` driven with 36'h008040201.
  - `frames_done` must then be 1.
- **Random frames with random bubbles.** Run 50 frames with random `in_valid` and `out_ready` gaps.
  - Each output frame must match a golden `ntt_4` of its input frame, in order.
  - No frame is lost or duplicated, and `frames_done` must be 50.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles in UNLOAD at `cnt`==2.
  - `out_data` stays equal to lane 2 throughout.
  - `in_ready` stays 0.
  - Output completes correctly once `out_ready` returns.
- **Input during busy.** Assert `in_valid` with 9'h1AB through COMPUTE and UNLOAD.
  - No accept occurs.
  - 9'h1AB becomes coefficient 0 of the next frame.
- **Reset mid-operation.** Load 2 coefficients, then pulse `rst` for 1 cycle, then load 1,2,3,4.
  - The output must match a golden `ntt_4` of lanes {1,2,3,4} (coefficient 0 = 1).
  - `frames_done` must be 1.
- **Counter wrap.** Force or preload `frames_done`=16'hFFFF, then complete one frame. `frames_done` must read 0.

Source files
------------

// File: rtl/ntt_4_sched.sv
// 4-point NTT (q = 257, w = 16) and its serial load / compute / unload sequencer.
// Coefficients stream in one per handshake and result words stream out low lane first.

module ntt_4 (
  input  logic [35:0] a,
  output logic [35:0] an
);
  localparam int unsigned Q = 257;
  localparam int unsigned W = 16;

  function automatic logic [31:0] md(input logic [31:0] v);
    return v % 32'(Q);
  endfunction

  logic [31:0] r0, r1, r2, r3, s02, d02, s13, d13w;
  logic [8:0]  x0, x1, x2, x3;

  // Radix-2 butterflies; w^2 = -1, so odd outputs share the twiddled difference.
  always_comb begin
    r0   = md(32'(a[8:0]));
    r1   = md(32'(a[17:9]));
    r2   = md(32'(a[26:18]));
    r3   = md(32'(a[35:27]));
    s02  = r0 + r2;
    d02  = r0 + 32'(Q) - r2;
    s13  = r1 + r3;
    d13w = md(32'(W) * md(r1 + 32'(Q) - r3));
    x0   = 9'(md(s02 + s13));
    x2   = 9'(md(s02 + 32'(2 * Q) - s13));
    x1   = 9'(md(d02 + d13w));
    x3   = 9'(md(d02 + 32'(Q) - d13w));
    an   = {x3, x2, x1, x0};
  end
endmodule

module ntt_4_sched #(
  parameter int unsigned COEF_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       frames_done
);
  localparam int unsigned FRAME_W = 4 * COEF_W;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] in_buf, res_buf, an;
  logic [1:0]         cnt;
  logic               in_acc, out_acc;

  ntt_4 u_ntt (
    .a  (in_buf),
    .an (an)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_acc && cnt == 2'd3) state_nxt = COMPUTE;
      COMPUTE: state_nxt = UNLOAD;
      UNLOAD:  if (out_acc && cnt == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Handshake flags come from the state register only; rst just masks in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    in_ready  = (state == LOAD) && !rst;
    out_valid = (state == UNLOAD);
    busy      = (state != LOAD);
    out_data  = res_buf[COEF_W*cnt +: COEF_W];
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
  end

  // Frame buffers, word index and frame counter; cnt wraps 3 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_buf      <= '0;
      res_buf     <= '0;
      cnt         <= 2'd0;
      frames_done <= 16'd0;
    end else begin
      if (in_acc) begin
        in_buf[COEF_W*cnt +: COEF_W] <= in_data;
        cnt                          <= cnt + 2'd1;
      end
      if (state == COMPUTE) res_buf <= an;
      if (out_acc) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) frames_done <= frames_done + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_ntt_4_sched.sv
// Self-checking bench for ntt_4_sched: random streams scored against a direct-sum NTT model.
`timescale 1ns/1ps

module tb_ntt_4_sched;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [8:0]  in_data, out_data;
  logic [15:0] frames_done;

  int checks = 0;
  int errors = 0;

  logic [8:0] in_q[$];
  logic [8:0] out_q[$];
  int   ncnt = 0, last_in_n = 0, first_v_n = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  ntt_4_sched #(.COEF_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .frames_done (frames_done)
  );

  // Record every completed handshake, sampled mid-cycle.
  always @(negedge clk) begin
    ncnt++;
    if (in_valid && in_ready) begin
      in_q.push_back(in_data);
      last_in_n = ncnt;
    end
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (out_valid && !prev_v) first_v_n = ncnt;
    prev_v = out_valid;
  end

  // Direct definition X[k] = sum a[j] * 16^(jk) mod 257.
  function automatic logic [8:0] gold(input logic [8:0] c0, c1, c2, c3, input int k);
    int a[4];
    int w[4];
    int s;
    a[0] = int'(c0) % 257;
    a[1] = int'(c1) % 257;
    a[2] = int'(c2) % 257;
    a[3] = int'(c3) % 257;
    w = '{1, 16, 256, 241};
    s = 0;
    for (int j = 0; j < 4; j++) s = (s + a[j] * w[(j * k) % 4]) % 257;
    return 9'(s);
  endfunction

  task automatic feed(input logic [8:0] w[$], input int vp, output bit ok);
    int i = 0;
    int guard = 0;
    bit acc;
    ok = 1'b1;
    while (i < w.size()) begin
      if (!in_valid && $urandom_range(99) < vp) begin
        in_valid = 1'b1;
        in_data  = w[i];
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        i++;
      end
      guard++;
      if (guard > 5000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain(input int n, input int rp, output bit ok);
    int got = 0;
    int guard = 0;
    bit acc;
    ok = 1'b1;
    while (got < n) begin
      out_ready = ($urandom_range(99) < rp);
      @(negedge clk);
      acc = out_valid && out_ready;
      @(posedge clk); #1;
      if (acc) got++;
      guard++;
      if (guard > 5000) begin
        ok = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 9'd0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (out_data !== 9'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++;
    if (frames_done !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d exp 0", frames_done); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    in_q.delete();
    out_q.delete();
  endtask

  task automatic test_single_ones();
    logic [8:0] w[$];
    logic [8:0] e;
    bit ok1, ok2;
    w = '{9'd1, 9'd1, 9'd1, 9'd1};
    fork
      feed(w, 100, ok1);
      drain(4, 100, ok2);
    join
    checks++;
    if (!ok1 || !ok2 || out_q.size() != 4) begin
      errors++; $display("FAIL ones_count got %0d exp 4", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = gold(9'd1, 9'd1, 9'd1, 9'd1, k);
        checks++;
        if (out_q[k] !== e) begin errors++; $display("FAIL ones_lane%0d got %h exp %h", k, out_q[k], e); end
      end
    end
    checks++;
    if (first_v_n - last_in_n != 2) begin
      errors++; $display("FAIL ones_latency got %0d exp 2", first_v_n - last_in_n);
    end
    checks++;
    if (frames_done !== 16'd1) begin errors++; $display("FAIL ones_frames got %0d exp 1", frames_done); end
  endtask

  task automatic test_random();
    logic [8:0] w[$];
    logic [8:0] e;
    bit ok1, ok2;
    int nf;
    apply_reset();
    for (int i = 0; i < 200; i++) w.push_back(9'($urandom_range(511)));
    fork
      feed(w, 60, ok1);
      drain(200, 60, ok2);
    join
    checks++;
    if (!ok1 || !ok2 || in_q.size() != 200 || out_q.size() != 200) begin
      errors++; $display("FAIL random_count in %0d out %0d exp 200", in_q.size(), out_q.size());
    end
    nf = (in_q.size() < out_q.size() ? in_q.size() : out_q.size()) / 4;
    for (int f = 0; f < nf; f++) begin
      checks++;
      if (in_q[4*f] !== w[4*f]) begin errors++; $display("FAIL random_in f%0d got %h exp %h", f, in_q[4*f], w[4*f]); end
      for (int k = 0; k < 4; k++) begin
        e = gold(in_q[4*f], in_q[4*f+1], in_q[4*f+2], in_q[4*f+3], k);
        checks++;
        if (out_q[4*f+k] !== e) begin
          errors++; $display("FAIL random f%0d k%0d got %h exp %h", f, k, out_q[4*f+k], e);
        end
      end
    end
    checks++;
    if (frames_done !== 16'd50) begin errors++; $display("FAIL random_frames got %0d exp 50", frames_done); end
  endtask

  task automatic test_backpressure();
    logic [8:0] w[$];
    logic [8:0] e;
    bit ok1, ok2;
    int g = 0;
    in_q.delete();
    out_q.delete();
    for (int i = 0; i < 4; i++) w.push_back(9'($urandom_range(511)));
    feed(w, 100, ok1);
    out_ready = 1'b1;
    while (out_q.size() < 2 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    e = gold(w[0], w[1], w[2], w[3], 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_data !== e || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d got %h/%b exp %h/1", c, out_data, out_valid, e);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
      @(posedge clk); #1;
    end
    drain(2, 100, ok2);
    checks++;
    if (!ok1 || !ok2 || out_q.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d exp 4", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = gold(w[0], w[1], w[2], w[3], k);
        checks++;
        if (out_q[k] !== e) begin errors++; $display("FAIL bp_lane%0d got %h exp %h", k, out_q[k], e); end
      end
    end
  endtask

  task automatic test_busy_input();
    logic [8:0] w[$];
    logic [8:0] w2[$];
    logic [8:0] e;
    bit ok1, ok2, ok3;
    int g = 0;
    in_q.delete();
    out_q.delete();
    for (int i = 0; i < 4; i++) w.push_back(9'($urandom_range(511)));
    feed(w, 100, ok1);
    in_valid = 1'b1;
    in_data = 9'h1AB;
    out_ready = 1'b1;
    while (out_q.size() < 4 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    checks++;
    if (in_q.size() != 4 || out_q.size() != 4) begin
      errors++; $display("FAIL busy_no_accept in %0d out %0d exp 4/4", in_q.size(), out_q.size());
    end
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_q.size() != 5) begin
      errors++; $display("FAIL busy_accept got %0d exp 5", in_q.size());
    end else begin
      checks++;
      if (in_q[4] !== 9'h1AB) begin errors++; $display("FAIL busy_coef0 got %h exp 1ab", in_q[4]); end
    end
    for (int i = 0; i < 3; i++) w2.push_back(9'($urandom_range(511)));
    fork
      feed(w2, 100, ok2);
      drain(4, 100, ok3);
    join
    checks++;
    if (!ok1 || !ok2 || !ok3 || out_q.size() != 8) begin
      errors++; $display("FAIL busy_count got %0d exp 8", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = gold(9'h1AB, w2[0], w2[1], w2[2], k);
        checks++;
        if (out_q[4+k] !== e) begin errors++; $display("FAIL busy_lane%0d got %h exp %h", k, out_q[4+k], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] w[$];
    logic [8:0] e;
    bit ok1, ok2;
    int g = 0;
    apply_reset();
    w = '{9'h0A5, 9'h133};
    feed(w, 100, ok1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
    w = '{9'd1, 9'd2, 9'd3, 9'd4};
    fork
      feed(w, 100, ok1);
      drain(4, 100, ok2);
    join
    checks++;
    if (!ok1 || !ok2 || out_q.size() != 4) begin
      errors++; $display("FAIL rmid_count got %0d exp 4", out_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = gold(9'd1, 9'd2, 9'd3, 9'd4, k);
        checks++;
        if (out_q[k] !== e) begin errors++; $display("FAIL rmid_lane%0d got %h exp %h", k, out_q[k], e); end
      end
    end
    checks++;
    if (frames_done !== 16'd1) begin errors++; $display("FAIL rmid_frames got %0d exp 1", frames_done); end
    // Reset in the middle of unload drops the frame uncounted.
    feed(w, 100, ok1);
    out_ready = 1'b1;
    while (out_q.size() < 5 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frames_done !== 16'd0) begin
      errors++; $display("FAIL runload got v%b b%b f%0d exp 0/0/0", out_valid, busy, frames_done);
    end
    in_q.delete();
    out_q.delete();
  endtask

  task automatic test_wrap();
    logic [8:0] w[$];
    bit ok1, ok2;
    @(negedge clk);
    force dut.frames_done = 16'hFFFF;
    @(negedge clk);
    release dut.frames_done;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) w.push_back(9'($urandom_range(511)));
    fork
      feed(w, 100, ok1);
      drain(4, 100, ok2);
    join
    checks++;
    if (!ok1 || !ok2 || frames_done !== 16'd0) begin
      errors++; $display("FAIL wrap_frames got %0d exp 0", frames_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 9'd0;
    @(posedge clk); #1;
    test_reset();
    test_single_ones();
    test_random();
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
